// File: rtl/xalu_ise_arb.sv
// xalu_ise_arb: shares one xalu_ise (x25519 maddlu/maddhu) between two requesters.
//
// Each requester has a val/rdy request channel and a val/rdy response channel
// backed by a one-entry response slot. A granted request is latched into a
// registered issue stage that drives the xalu_ise ise_* inputs. xalu_ise
// answers combinationally, so its result is captured into the owning slot on
// the following edge. Request-to-response latency is 2 cycles, and the
// aggregate throughput is one op per cycle.
//
// Ports
//   ise_clk, ise_rst        clock, asynchronous active-low reset
//   rq_val/rq_rdy           per-requester request handshake (bit i = requester i)
//   rq_fn/imm/in1/in2/in3   per-requester operation and operands, packed by requester
//   rq_tag                  opaque tag, returned with the response
//   rsp_val/rsp_rdy         per-requester response handshake
//   rsp_out/rsp_tag/rsp_err response data; err=1 means xalu_ise did not decode the op
//   ise_fn..ise_in3,ise_val registered issue stage to xalu_ise
//   ise_oval, ise_out       result from xalu_ise
//
// Configuration
//   XALU_ARB_RR_EN  defined: round-robin arbitration on ties.
//                   undefined: fixed priority, requester 0 wins ties.
//
// Slot states
//   state   | meaning
//   S_EMPTY | no op outstanding, requester may be granted
//   S_BUSY  | op granted, sitting in the issue register this cycle
//   S_FULL  | result held, rsp_val=1 until consumed
module xalu_ise_arb #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 4
) (
   input  logic                 ise_clk,
   input  logic                 ise_rst,
   input  logic [1:0]           rq_val,
   output logic [1:0]           rq_rdy,
   input  logic [11:0]          rq_fn,
   input  logic [13:0]          rq_imm,
   input  logic [2*XLEN-1:0]    rq_in1,
   input  logic [2*XLEN-1:0]    rq_in2,
   input  logic [2*XLEN-1:0]    rq_in3,
   input  logic [2*TAG_W-1:0]   rq_tag,
   output logic [1:0]           rsp_val,
   input  logic [1:0]           rsp_rdy,
   output logic [2*XLEN-1:0]    rsp_out,
   output logic [2*TAG_W-1:0]   rsp_tag,
   output logic [1:0]           rsp_err,
   output logic [5:0]           ise_fn,
   output logic [6:0]           ise_imm,
   output logic [XLEN-1:0]      ise_in1,
   output logic [XLEN-1:0]      ise_in2,
   output logic [XLEN-1:0]      ise_in3,
   output logic                 ise_val,
   input  logic                 ise_oval,
   input  logic [XLEN-1:0]      ise_out
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } slot_e;

   slot_e             slot_q    [2];
   logic [XLEN-1:0]   rsp_out_q [2];
   logic [TAG_W-1:0]  rsp_tag_q [2];
   logic [1:0]        rsp_err_q;

   logic [5:0]        fn_q;
   logic [6:0]        imm_q;
   logic [XLEN-1:0]   in1_q;
   logic [XLEN-1:0]   in2_q;
   logic [XLEN-1:0]   in3_q;
   logic [TAG_W-1:0]  tag_q;
   logic              sel_q;
   logic              ise_val_q;

   logic [1:0]        elig;
   logic [1:0]        grant;
   logic              gsel;

`ifdef XALU_ARB_RR_EN
   logic              ptr_q;
   logic              ptr_d;
`endif

   // A FULL slot may be re-granted in the same cycle its response is consumed,
   // which is what gives back-to-back issue without a bubble.
   always_comb begin
      elig = 2'b00;
      for (int i = 0; i < 2; i++) begin
         elig[i] = rq_val[i] &
                   ((slot_q[i] == S_EMPTY) | ((slot_q[i] == S_FULL) & rsp_rdy[i]));
      end
   end

`ifdef XALU_ARB_RR_EN
   always_comb begin
      grant = elig;
      if (elig == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end
      // After any grant the other requester is preferred next time.
      ptr_d = ptr_q;
      if (|grant) begin
         ptr_d = ~grant[1];
      end
   end

   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      grant = elig;
      if (elig[0]) begin
         grant = 2'b01;
      end
   end
`endif

   assign gsel   = grant[1];
   assign rq_rdy = grant;

   // Issue stage: loaded on every grant, holds its contents otherwise.
   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         fn_q      <= '0;
         imm_q     <= '0;
         in1_q     <= '0;
         in2_q     <= '0;
         in3_q     <= '0;
         tag_q     <= '0;
         sel_q     <= 1'b0;
         ise_val_q <= 1'b0;
      end else begin
         ise_val_q <= |grant;
         if (|grant) begin
            sel_q <= gsel;
            fn_q  <= gsel ? rq_fn[11:6]              : rq_fn[5:0];
            imm_q <= gsel ? rq_imm[13:7]             : rq_imm[6:0];
            in1_q <= gsel ? rq_in1[2*XLEN-1:XLEN]    : rq_in1[XLEN-1:0];
            in2_q <= gsel ? rq_in2[2*XLEN-1:XLEN]    : rq_in2[XLEN-1:0];
            in3_q <= gsel ? rq_in3[2*XLEN-1:XLEN]    : rq_in3[XLEN-1:0];
            tag_q <= gsel ? rq_tag[2*TAG_W-1:TAG_W]  : rq_tag[TAG_W-1:0];
         end
      end
   end

   assign ise_fn  = fn_q;
   assign ise_imm = imm_q;
   assign ise_in1 = in1_q;
   assign ise_in2 = in2_q;
   assign ise_in3 = in3_q;
   assign ise_val = ise_val_q;

   // Slot FSMs. A slot is BUSY for exactly the one cycle its op occupies the
   // issue stage, so the capture condition always holds in S_BUSY.
   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         for (int i = 0; i < 2; i++) begin
            slot_q[i]    <= S_EMPTY;
            rsp_out_q[i] <= '0;
            rsp_tag_q[i] <= '0;
         end
         rsp_err_q <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (slot_q[i])
               S_EMPTY: begin
                  if (grant[i]) begin
                     slot_q[i] <= S_BUSY;
                  end
               end
               S_BUSY: begin
                  if (ise_val_q && (sel_q == i[0])) begin
                     slot_q[i]    <= S_FULL;
                     rsp_out_q[i] <= ise_oval ? ise_out : '0;
                     rsp_err_q[i] <= ~ise_oval;
                     rsp_tag_q[i] <= tag_q;
                  end
               end
               S_FULL: begin
                  if (grant[i]) begin
                     slot_q[i] <= S_BUSY;
                  end else if (rsp_rdy[i]) begin
                     slot_q[i] <= S_EMPTY;
                  end
               end
               default: slot_q[i] <= S_EMPTY;
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rsp_val[i] = (slot_q[i] == S_FULL);
      end
   end

   assign rsp_out = {rsp_out_q[1], rsp_out_q[0]};
   assign rsp_tag = {rsp_tag_q[1], rsp_tag_q[0]};
   assign rsp_err = rsp_err_q;

endmodule
